// File: rtl/fifo_push_arbiter_pkg.sv
// Shared widths and helpers for the FIFO push arbiter.
// Also carries the defines shared with the FIFO and scoreboard.
`ifndef FIFO_PUSH_ARBITER
`define FIFO_PUSH_ARBITER

`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif

`ifndef ARB_QWID
`define ARB_QWID 2
`endif

`ifndef ARB_NREQ
`define ARB_NREQ 4
`endif

`endif

package fifo_push_arbiter_pkg;

    localparam int ARB_WIDTH = `FIFO_DWIDTH;
    localparam int ARB_NREQ  = `ARB_NREQ;
    localparam int ARB_QWID  = `ARB_QWID;

    // Round-robin successor of a requester index, wrapping at nreq-1.
    function automatic int rr_next(input int id, input int nreq);
        return (id >= nreq - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Requester and FIFO push-side signals of the arbiter.
// master = arbiter side, slave = requesters/FIFO harness.
interface fifo_push_arbiter_if
    import fifo_push_arbiter_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH,
    parameter int NREQ  = ARB_NREQ,
    parameter int QWID  = ARB_QWID
);

    logic [NREQ-1:0]       req_vld;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_rdy;
    logic                  full;
    logic                  push;
    logic [WIDTH-1:0]      data_in;
    logic [QWID-1:0]       push_qid;
    logic                  busy;

    modport master (
        input  req_vld,
        input  req_data,
        input  full,
        output req_rdy,
        output push,
        output data_in,
        output push_qid,
        output busy
    );

    modport slave (
        output req_vld,
        output req_data,
        output full,
        input  req_rdy,
        input  push,
        input  data_in,
        input  push_qid,
        input  busy
    );

endinterface

// File: rtl/fifo_push_arbiter_rr_arbiter.sv
// Combinational round-robin grant scan starting at ptr.
// Grant is gated by en; gnt_id/any always reflect the scan.
module rr_arbiter
    import fifo_push_arbiter_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int QWID = ARB_QWID
) (
    input  logic [NREQ-1:0] req,
    input  logic [QWID-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [QWID-1:0] gnt_id,
    output logic            any
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    int   idx;
    logic found;

    // Scan ptr, ptr+1, ... mod NREQ and take the first request.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        any    = |req;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx[IW-1:0]]) begin
                found  = 1'b1;
                gnt_id = QWID'(idx);
                if (en) begin
                    grant[idx[IW-1:0]] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Merges NREQ requesters into one FIFO push port through a
// round-robin arbiter and a single registered output slot.
module fifo_push_arbiter
    import fifo_push_arbiter_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH,
    parameter int NREQ  = ARB_NREQ,
    parameter int QWID  = ARB_QWID
) (
    input  logic                clk,
    input  logic                rst,
    fifo_push_arbiter_if.master bus
);

    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic [QWID-1:0]  out_qid;
    logic [QWID-1:0]  rr_ptr;

    logic             push_w;
    logic             load;
    logic [NREQ-1:0]  grant;
    logic [QWID-1:0]  gnt_id;
    logic             any;
    logic [WIDTH-1:0] sel_data;
    logic [QWID-1:0]  nxt_ptr;

    // The slot drains when the FIFO has room; reset blocks it at once.
    assign push_w = !rst && out_vld && !bus.full;

    // The slot can take a word when empty or leaving this cycle.
    assign load = !rst && (!out_vld || push_w);

    rr_arbiter #(
        .NREQ (NREQ),
        .QWID (QWID)
    ) u_arb (
        .req    (bus.req_vld),
        .ptr    (rr_ptr),
        .en     (load),
        .grant  (grant),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign bus.req_rdy  = grant;
    assign bus.push     = push_w;
    assign bus.data_in  = out_data;
    assign bus.push_qid = out_qid;
    assign bus.busy     = out_vld;

    // Select the granted requester's word from the flat bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == QWID'(i)) begin
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves just past the winner, wrapping explicitly.
    assign nxt_ptr = (gnt_id == QWID'(NREQ - 1)) ? '0 : gnt_id + QWID'(1);

    // Output slot and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_qid  <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            if (any) begin
                out_vld  <= 1'b1;
                out_data <= sel_data;
                out_qid  <= gnt_id;
                rr_ptr   <= nxt_ptr;
            end else begin
                out_vld  <= 1'b0;
            end
        end
    end

`ifdef FORMAL
    logic past_ok;

    // Marks cycles where $past values are meaningful.
    always_ff @(posedge clk) begin
        past_ok <= 1'b1;
    end

    // Safety properties of the push port and pointer.
    always_ff @(posedge clk) begin
        assert (!(bus.push && bus.full));
        assert ($onehot0(bus.req_rdy));
        assert (int'(rr_ptr) < NREQ);
        if (past_ok && !rst && !$past(rst) && $past(out_vld && bus.full)) begin
            assert (out_data == $past(out_data));
            assert (out_qid == $past(out_qid));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed table vectors, hand sequences for backpressure and
// reset, and an end-to-end run into a depth-4 FIFO model.
module tb_fifo_push_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int Q = 2;

    logic clk;
    logic rst;

    fifo_push_arbiter_if #(.WIDTH(W), .NREQ(N), .QWID(Q)) bus ();

    fifo_push_arbiter #(
        .WIDTH (W),
        .NREQ  (N),
        .QWID  (Q)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       full;
        logic [3:0] rdy;
        logic       push;
        logic       chk_d;
        logic [7:0] data;
        logic [1:0] qid;
    } vec_t;

    vec_t vecs[17];

    int n_cmp;
    int n_bad;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [7:0] exp_q[4][$];
    logic [9:0] fifo_q[$];
    logic [3:0] vld_r;
    logic [7:0] pdat[4];
    int         n_acc;
    int         n_pop;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req_vld = '0;
        bus.full = 1'b0;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        //            rst vld      full rdy      push chk data  qid
        vecs[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0};
        vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 8'h00, 2'd0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h00, 2'd0};
        vecs[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 8'hA0, 2'd0};
        vecs[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, 8'hA1, 2'd1};
        vecs[5]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 8'hA2, 2'd2};
        vecs[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1, 8'hA3, 2'd3};
        vecs[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 8'hA0, 2'd0};
        vecs[8]  = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 8'hA1, 2'd1};
        vecs[9]  = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'hA3, 2'd3};
        vecs[10] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 8'hA0, 2'd0};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hA3, 2'd3};
        vecs[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 8'hA3, 2'd3};
        vecs[13] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 8'hA3, 2'd3};
        vecs[14] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1, 8'hA2, 2'd2};
        vecs[15] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 8'hA2, 2'd2};
        vecs[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 8'hA2, 2'd2};

        // Table: reset, round-robin, skip/wrap, full with empty slot.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            bus.req_vld = vecs[i].vld;
            bus.full = vecs[i].full;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(bus.req_rdy), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_push", i), 32'(bus.push), 32'(vecs[i].push));
            if (vecs[i].chk_d) begin
                chk($sformatf("v%0d_data", i), 32'(bus.data_in),
                    32'(vecs[i].data));
                chk($sformatf("v%0d_qid", i), 32'(bus.push_qid),
                    32'(vecs[i].qid));
            end
        end

        // Backpressure: hold 8'h5A for 5 full cycles.
        @(negedge clk);
        rst = 1'b1;
        bus.req_vld = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_data = {8'hD3, 8'hC2, 8'h77, 8'h5A};
        bus.req_vld = 4'b0001;
        #1;
        chk("bp_first_rdy", 32'(bus.req_rdy), 32'h1);
        @(negedge clk);
        bus.req_vld = 4'b0010;
        bus.full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_hold%0d_data", k), 32'(bus.data_in), 32'h5A);
            chk($sformatf("bp_hold%0d_push", k), 32'(bus.push), 32'h0);
            chk($sformatf("bp_hold%0d_rdy", k), 32'(bus.req_rdy), 32'h0);
            @(negedge clk);
        end
        bus.full = 1'b0;
        #1;
        chk("bp_rel_push", 32'(bus.push), 32'h1);
        chk("bp_rel_data", 32'(bus.data_in), 32'h5A);
        chk("bp_rel_rdy", 32'(bus.req_rdy), 32'h2);
        @(negedge clk);
        bus.req_vld = '0;
        #1;
        chk("bp_next_push", 32'(bus.push), 32'h1);
        chk("bp_next_data", 32'(bus.data_in), 32'h77);
        chk("bp_next_qid", 32'(bus.push_qid), 32'h1);

        // Reset mid-op: 8'h33 held under full, then reset.
        @(negedge clk);
        bus.req_data = {8'hD3, 8'hC2, 8'h77, 8'h33};
        bus.full = 1'b1;
        bus.req_vld = 4'b0001;
        #1;
        chk("rm_load_rdy", 32'(bus.req_rdy), 32'h1);
        @(negedge clk);
        bus.req_vld = '0;
        bus.req_data = {8'hD3, 8'hC2, 8'h77, 8'h11};
        #1;
        chk("rm_held_busy", 32'(bus.busy), 32'h1);
        chk("rm_held_data", 32'(bus.data_in), 32'h33);
        chk("rm_held_push", 32'(bus.push), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.full = 1'b0;
        #1;
        chk("rm_rst_push", 32'(bus.push), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_vld = 4'b1111;
        #1;
        chk("rm_after_busy", 32'(bus.busy), 32'h0);
        chk("rm_after_push", 32'(bus.push), 32'h0);
        chk("rm_after_rdy", 32'(bus.req_rdy), 32'h1);
        @(negedge clk);
        bus.req_vld = '0;
        #1;
        chk("rm_new_push", 32'(bus.push), 32'h1);
        chk("rm_new_data", 32'(bus.data_in), 32'h11);
        @(negedge clk);

        // End-to-end into a depth-4 FIFO with random pops.
        vld_r = '0;
        n_acc = 0;
        n_pop = 0;
        for (int c = 0; c < 280; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (c < 200 && !vld_r[i] && $urandom_range(0, 2) != 0) begin
                    vld_r[i] = 1'b1;
                    pdat[i] = 8'($urandom);
                end
                bus.req_data[i*W +: W] = pdat[i];
            end
            bus.req_vld = vld_r;
            bus.full = (fifo_q.size() >= 4);
            #1;
            if (!$onehot0(bus.req_rdy)) begin
                chk("e2e_onehot", 32'(bus.req_rdy), 32'h0);
            end
            if (bus.push && bus.full) begin
                chk("e2e_push_full", 32'(bus.push), 32'h0);
            end
            if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                logic [9:0] it;
                it = fifo_q.pop_front();
                n_pop++;
                if (exp_q[it[9:8]].size() == 0) begin
                    chk("e2e_unexpected", 32'(it), 32'h3FF);
                end else begin
                    chk($sformatf("e2e_order_q%0d", it[9:8]), 32'(it[7:0]),
                        32'(exp_q[it[9:8]].pop_front()));
                end
            end
            if (bus.push) begin
                if (fifo_q.size() >= 4) begin
                    chk("e2e_overflow", 32'(fifo_q.size()), 32'd3);
                end
                fifo_q.push_back({bus.push_qid, bus.data_in});
            end
            for (int i = 0; i < N; i++) begin
                if (vld_r[i] && bus.req_rdy[i]) begin
                    exp_q[i].push_back(pdat[i]);
                    vld_r[i] = 1'b0;
                    n_acc++;
                end
            end
        end
        chk("e2e_drained", 32'(exp_q[0].size() + exp_q[1].size() +
            exp_q[2].size() + exp_q[3].size() + fifo_q.size()), 32'd0);
        chk("e2e_count", 32'(n_pop), 32'(n_acc));
        if (n_acc < 20) begin
            chk("e2e_activity", 32'(n_acc), 32'd20);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
